// File: rtl/ccd_capture_window.sv
// Camera capture front end. It registers the sensor bus and applies a programmable
// window with 1/2/4 decimation. Accepted pixels are packed into 16-bit words, and each
// word is queued with its SDRAM word address in a small FIFO that feeds the SDRAM writer.
module ccd_capture_window #(
  parameter int DATA_W       = 12,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 2,
  parameter int ADDR_W       = 23,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iF_valid,
  input  logic              iL_valid,
  input  logic [DATA_W-1:0] iCam_data,
  input  logic              iRun,
  input  logic              iStop,
  input  logic [15:0]       iWin_x0,
  input  logic [15:0]       iWin_y0,
  input  logic [15:0]       iWin_w,
  input  logic [15:0]       iWin_h,
  input  logic [1:0]        iDecim,
  input  logic [ADDR_W-1:0] iBase_addr,
  input  logic              iSDRAM_busy_in,
  output logic              oXCLKIN,
  output logic [15:0]       oSDRAM_data,
  output logic [ADDR_W-1:0] oSDRAM_addr,
  output logic              oSDRAM_valid,
  output logic              oFrame_done,
  output logic              oOverflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int ENT_W  = ADDR_W + 16;

  typedef enum logic [1:0] {WAIT_GAP, WAIT_FRAME, CAPTURE, STOPPED} state_t;

  // Registered camera and control inputs
  logic             f_valid_q, l_valid_q, l_valid_prev_q, run_q, stop_req_q;
  logic [PIX_W-1:0] pix_q;

  // Frame state, window latched at frame start, packer and FIFO
  state_t            state_q;
  logic [15:0]       x_q, y_q, win_x0_q, win_y0_q, win_w_q, win_h_q;
  logic [1:0]        dmask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       word_q;
  logic [SLOT_W-1:0] slot_q;
  logic              stop_flag_q;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Combinational decisions
  logic [16:0] x_end, y_end;
  logic [15:0] dx, dy, merged, push_word;
  logic        in_win, capturing, frame_end, line_fall, accept, last_slot;
  logic        flush, push, fifo_full, pop, wr_en, drop, stop_flag_d;
  logic        unused_bits;

  assign unused_bits = ^{iCam_data[DATA_W-PIX_W-1:0], dx[15:2], dy[15:2]};

  // Sample the sensor bus and control strobes once; everything downstream uses these copies
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // F_valid copy resets high so a frame already in flight at reset release is
      // never mistaken for the gap that must precede a capture.
      f_valid_q      <= 1'b1;
      l_valid_q      <= 1'b0;
      l_valid_prev_q <= 1'b0;
      pix_q          <= '0;
      run_q          <= 1'b0;
      stop_req_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register in the
      // design updates from the same pre-edge values, regardless of block ordering.
      f_valid_q      <= iF_valid;
      l_valid_q      <= iL_valid;
      l_valid_prev_q <= l_valid_q;
      pix_q          <= iCam_data[DATA_W-1 -: PIX_W];
      run_q          <= iRun;
      stop_req_q     <= iStop;
    end
  end

  // Window test, pixel packing, push/flush and FIFO handshake decisions
  always_comb begin
    // NOTE: every combinational output gets a default before any branch; a path that
    // leaves one unassigned would otherwise infer a latch.
    x_end       = {1'b0, win_x0_q} + {1'b0, win_w_q};
    y_end       = {1'b0, win_y0_q} + {1'b0, win_h_q};
    dx          = x_q - win_x0_q;
    dy          = y_q - win_y0_q;
    in_win      = (x_q >= win_x0_q) && ({1'b0, x_q} < x_end) &&
                  (y_q >= win_y0_q) && ({1'b0, y_q} < y_end) &&
                  ((dx[1:0] & dmask_q) == 2'b00) && ((dy[1:0] & dmask_q) == 2'b00);
    capturing   = (state_q == CAPTURE) && f_valid_q;
    frame_end   = (state_q == CAPTURE) && !f_valid_q;
    line_fall   = l_valid_prev_q && !l_valid_q;
    accept      = capturing && l_valid_q && in_win;
    last_slot   = (slot_q == SLOT_W'(PIX_PER_WORD - 1));
    merged      = word_q;
    merged[int'(slot_q)*PIX_W +: PIX_W] = pix_q;
    flush       = (frame_end || (capturing && line_fall)) && (slot_q != '0);
    push        = (accept && last_slot) || flush;
    push_word   = accept ? merged : word_q;
    fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    pop         = (count_q != '0) && !iSDRAM_busy_in;
    wr_en       = push && (!fifo_full || pop);
    drop        = push && fifo_full && !pop;
    stop_flag_d = run_q ? 1'b0 : (stop_req_q | stop_flag_q);
  end

  // Frame sequencing, x/y counters, packer, address counter and status outputs
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= WAIT_GAP;
      x_q         <= '0;
      y_q         <= '0;
      win_x0_q    <= '0;
      win_y0_q    <= '0;
      win_w_q     <= '0;
      win_h_q     <= '0;
      dmask_q     <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      slot_q      <= '0;
      stop_flag_q <= 1'b0;
      oFrame_done <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      oFrame_done <= 1'b0;
      stop_flag_q <= stop_flag_d;
      if (drop) oOverflow <= 1'b1;
      // Dropped words still consume their address so later words land where expected
      if (push) addr_q <= addr_q + 1'b1;
      unique case (state_q)
        WAIT_GAP: if (!f_valid_q) state_q <= WAIT_FRAME;
        WAIT_FRAME: if (f_valid_q) begin
          win_x0_q  <= iWin_x0;
          win_y0_q  <= iWin_y0;
          win_w_q   <= iWin_w;
          win_h_q   <= iWin_h;
          dmask_q   <= (iDecim == 2'd0) ? 2'b00 : (iDecim == 2'd1) ? 2'b01 : 2'b11;
          addr_q    <= iBase_addr;
          oOverflow <= 1'b0;
          x_q       <= '0;
          y_q       <= '0;
          word_q    <= '0;
          slot_q    <= '0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (!f_valid_q) begin
            oFrame_done <= 1'b1;
            word_q      <= '0;
            slot_q      <= '0;
            state_q     <= stop_flag_d ? STOPPED : WAIT_FRAME;
          end else begin
            if (!l_valid_q)        x_q <= '0;
            else if (x_q != '1)    x_q <= x_q + 16'd1;
            if (line_fall && y_q != '1) y_q <= y_q + 16'd1;
            if (accept && last_slot) begin
              word_q <= '0;
              slot_q <= '0;
            end else if (accept) begin
              word_q <= merged;
              slot_q <= slot_q + 1'b1;
            end else if (flush) begin
              word_q <= '0;
              slot_q <= '0;
            end
          end
        end
        STOPPED: if (run_q) state_q <= WAIT_GAP;
        default: state_q <= WAIT_GAP;
      endcase
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop is legal even when full
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: {address, data} per entry
  always_ff @(posedge iCLK) begin
    // NOTE: storage has no reset; an entry is only observable once written, and the
    // outputs are gated by occupancy so stale contents never reach the pins.
    if (wr_en) mem_q[wr_ptr_q] <= {addr_q, push_word};
  end

  assign oXCLKIN      = iCLK;
  assign oSDRAM_valid = (count_q != '0);
  assign oSDRAM_data  = oSDRAM_valid ? mem_q[rd_ptr_q][15:0] : '0;
  assign oSDRAM_addr  = oSDRAM_valid ? mem_q[rd_ptr_q][ENT_W-1:16] : '0;

endmodule

// File: tb/tb_ccd_capture_window.sv
// Self-checking bench for ccd_capture_window. Frames of random or ramp pixels are driven
// into the design. A line-oriented reference model derives the expected (address, data)
// word stream from the window and decimation rules, and the bench compares it with the
// words popped from the design.
module tb_ccd_capture_window;
  localparam int ADDR_W = 23;
  localparam int PPW    = 2;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, f_valid, l_valid, run, stop, busy;
  logic [11:0]       cam_data;
  logic [15:0]       win_x0, win_y0, win_w, win_h;
  logic [1:0]        decim;
  logic [ADDR_W-1:0] base;
  logic              xclk, sd_valid, frame_done, overflow;
  logic [15:0]       sd_data;
  logic [ADDR_W-1:0] sd_addr;

  ccd_capture_window dut (
    .iCLK(clk), .iRST(rst_n), .iF_valid(f_valid), .iL_valid(l_valid),
    .iCam_data(cam_data), .iRun(run), .iStop(stop),
    .iWin_x0(win_x0), .iWin_y0(win_y0), .iWin_w(win_w), .iWin_h(win_h),
    .iDecim(decim), .iBase_addr(base), .iSDRAM_busy_in(busy),
    .oXCLKIN(xclk), .oSDRAM_data(sd_data), .oSDRAM_addr(sd_addr),
    .oSDRAM_valid(sd_valid), .oFrame_done(frame_done), .oOverflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int busy_mode = 0;  // 0: never busy, 1: random isolated busy cycles, 2: always busy
  int done_cnt = 0;
  logic [11:0]       pix [16][32];
  logic [ADDR_W+15:0] got_q[$];
  logic [ADDR_W+15:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Busy generator, updated just after each active edge
  always @(posedge clk) begin
    #1;
    case (busy_mode)
      1:       busy = !busy && ($urandom_range(0, 3) == 0);
      2:       busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Monitor: a word is consumed when valid and not busy at the next edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (sd_valid && !busy) got_q.push_back({sd_addr, sd_data});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic fill_pix(input int mode);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++)
        pix[y][x] = (mode == 0) ? 12'((y * 32 + x) * 37 + 5) : 12'($urandom);
  endtask

  task automatic set_win(input int x0, y0, w, h, dec, input logic [ADDR_W-1:0] b);
    win_x0 = 16'(x0); win_y0 = 16'(y0); win_w = 16'(w); win_h = 16'(h);
    decim  = 2'(dec); base = b;
  endtask

  // Reference: per line, list the accepted pixels, then cut the list into words of PPW
  // pixels (the short last group zero-padded); addresses count up from the frame base.
  task automatic model(input int fw, fh, trunc);
    int dv, ix0, iy0, iw, ih, n;
    logic [ADDR_W-1:0] a;
    logic [7:0]  line_pix[$];
    logic [15:0] w;
    dv  = (decim == 2'd0) ? 1 : (decim == 2'd1) ? 2 : 4;
    ix0 = int'(win_x0); iy0 = int'(win_y0); iw = int'(win_w); ih = int'(win_h);
    a   = base;
    for (int y = 0; y < fh; y++) begin
      n = (trunc >= 0 && y == fh - 1) ? trunc : fw;
      line_pix.delete();
      for (int x = 0; x < n; x++)
        if (x >= ix0 && x < ix0 + iw && y >= iy0 && y < iy0 + ih &&
            (x - ix0) % dv == 0 && (y - iy0) % dv == 0)
          line_pix.push_back(pix[y][x][11:4]);
      while (line_pix.size() > 0) begin
        w = '0;
        for (int s = 0; s < PPW; s++)
          if (line_pix.size() > 0) w[s*8 +: 8] = line_pix.pop_front();
        exp_q.push_back({a, w});
        a = a + 1'b1;
      end
    end
  endtask

  // One camera frame; trunc>=0 drops F_valid mid-way through the last line,
  // stop_line>=0 pulses iStop at the first sample of that line.
  task automatic drive_frame(input int fw, fh, trunc, stop_line);
    int n;
    f_valid = 1'b1;
    tick(3);
    for (int y = 0; y < fh; y++) begin
      n = (trunc >= 0 && y == fh - 1) ? trunc : fw;
      for (int x = 0; x < n; x++) begin
        l_valid  = 1'b1;
        cam_data = pix[y][x];
        stop     = (y == stop_line && x == 0);
        tick();
      end
      stop = 1'b0;
      if (trunc >= 0 && y == fh - 1) begin
        f_valid  = 1'b0;
        cam_data = 12'hfff;
        tick();
        l_valid = 1'b0;
        tick();
      end else begin
        l_valid = 1'b0;
        tick(3);
      end
    end
    if (trunc < 0) begin
      tick(2);
      f_valid = 1'b0;
    end
    tick(8);
  endtask

  task automatic settle(input int exp_done, input string tag);
    int guard = 0;
    int m;
    while ((got_q.size() < exp_q.size() || sd_valid) && guard < 400) begin
      tick();
      guard++;
    end
    tick(3);
    check({tag, " word count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s word %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, " frame_done"}, 64'(done_cnt), 64'(exp_done));
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    int fw, fh, dec, dv, x0, y0, w, h, trunc;
    rst_n = 1'b0; f_valid = 1'b0; l_valid = 1'b0; cam_data = '0; run = 1'b0; stop = 1'b0;
    busy = 1'b0;
    set_win(0, 0, 0, 0, 0, '0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset valid", 64'(sd_valid), 64'd0);
    check("reset data", 64'(sd_data), 64'd0);
    check("reset addr", 64'(sd_addr), 64'd0);
    check("reset done", 64'(frame_done), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("xclkin follows clk", 64'(xclk), 64'(clk));

    // Full 8x4 window, no decimation, ramp pixels
    fill_pix(0);
    set_win(0, 0, 8, 4, 0, 23'h000100);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "full");

    // Sub-window on the same ramp
    set_win(2, 1, 4, 2, 0, 23'h002000);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "window");

    // Decimate by 2, base placed to wrap the address counter
    set_win(0, 0, 8, 4, 1, 23'h7ffffe);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "decim2 wrap");

    // Backpressure: busy for the whole frame keeps only the first DEPTH words
    set_win(0, 0, 8, 4, 0, 23'h000040);
    busy_mode = 2;
    tick();
    model(8, 4, -1);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    drive_frame(8, 4, -1, -1);
    check("overflow set", 64'(overflow), 64'd1);
    check("overflow fifo valid", 64'(sd_valid), 64'd1);
    busy_mode = 0;
    settle(1, "overflow");
    check("overflow sticky", 64'(overflow), 64'd1);
    fill_pix(1);
    set_win(1, 0, 4, 3, 0, 23'h000080);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    check("overflow cleared", 64'(overflow), 64'd0);
    settle(1, "after overflow");

    // Stop mid-frame: frame completes, next frame ignored until iRun
    set_win(0, 0, 8, 4, 0, 23'h000300);
    model(8, 4, -1);
    drive_frame(8, 4, -1, 1);
    settle(1, "stop frame");
    drive_frame(8, 4, -1, -1);
    settle(0, "stopped");
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(3);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "resumed");
    run = 1'b1;
    stop = 1'b1;
    tick();
    run = 1'b0;
    stop = 1'b0;
    tick(2);
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "run+stop");
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "still running");

    // Odd line length (line-end flush) and F_valid falling mid-line (frame-end flush)
    set_win(0, 0, 16, 4, 0, 23'h000500);
    model(9, 3, 5);
    drive_frame(9, 3, 5, -1);
    settle(1, "truncated");

    // Reset in the middle of a line: outputs clear, rest of that frame ignored
    set_win(0, 0, 8, 4, 0, 23'h000600);
    f_valid = 1'b1;
    tick(3);
    for (int x = 0; x < 5; x++) begin
      l_valid = 1'b1; cam_data = pix[0][x]; tick();
    end
    rst_n = 1'b0;
    #1;
    check("midreset valid", 64'(sd_valid), 64'd0);
    check("midreset data", 64'(sd_data), 64'd0);
    check("midreset addr", 64'(sd_addr), 64'd0);
    check("midreset overflow", 64'(overflow), 64'd0);
    got_q.delete();
    done_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    for (int x = 0; x < 5; x++) begin
      cam_data = pix[0][x]; tick();
    end
    l_valid = 1'b0;
    tick(3);
    for (int x = 0; x < 8; x++) begin
      l_valid = 1'b1; cam_data = pix[1][x]; tick();
    end
    l_valid = 1'b0;
    tick(2);
    f_valid = 1'b0;
    tick(8);
    settle(0, "post-reset frame");
    model(8, 4, -1);
    drive_frame(8, 4, -1, -1);
    settle(1, "after reset");

    // Randomized frames, windows, decimation, bases and isolated busy cycles
    busy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      fw    = $urandom_range(4, 20);
      fh    = $urandom_range(2, 8);
      dec   = $urandom_range(0, 3);
      dv    = (dec == 0) ? 1 : (dec == 1) ? 2 : 4;
      x0    = $urandom_range(0, fw - 1);
      y0    = $urandom_range(0, fh - 1);
      w     = dv * PPW * $urandom_range(1, 4);
      h     = $urandom_range(1, fh);
      trunc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fw - 1) : -1;
      fill_pix(1);
      set_win(x0, y0, w, h, dec, 23'($urandom));
      model(fw, fh, trunc);
      drive_frame(fw, fh, trunc, -1);
      settle(1, $sformatf("random %0d", i));
      check($sformatf("random %0d overflow", i), 64'(overflow), 64'd0);
    end
    busy_mode = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
